// File: rtl/step_counter.sv
// Registered WIDTH-bit up/down counter with programmable step and modulus.
// Over/underflow either wraps modulo MAX_VAL+1 or clamps, and is reported via carry/ovf_sticky.
module step_counter #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              en,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  count,
  output logic              carry,
  output logic              at_max,
  output logic              at_min,
  output logic              ovf_sticky
);

  if (MAX_VAL >= (1 << WIDTH) || ((1 << STEP_W) - 1) > MAX_VAL) begin : g_bad_params
    $fatal(1, "step_counter: MAX_VAL must fit in WIDTH and the largest step must not exceed MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_W};
  localparam logic [WIDTH:0]   MOD_EXT = MAX_EXT + (WIDTH+1)'(1);

  // Results are packed as {carry, next_count}; one guard bit is enough since step <= MAX_VAL.
  function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] c,
                                              input logic [STEP_W-1:0] s);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] res;
    sum = {1'b0, c} + (WIDTH+1)'(s);
    if (sum <= MAX_EXT)      res = {1'b0, WIDTH'(sum)};
    else if (SATURATE != 0)  res = {1'b1, MAX_W};
    else                     res = {1'b1, WIDTH'(sum - MOD_EXT)};
    return res;
  endfunction

  function automatic logic [WIDTH:0] step_dn(input logic [WIDTH-1:0] c,
                                              input logic [STEP_W-1:0] s);
    logic [WIDTH:0] cw;
    logic [WIDTH:0] sw;
    logic [WIDTH:0] res;
    cw = {1'b0, c};
    sw = (WIDTH+1)'(s);
    if (sw <= cw)            res = {1'b0, WIDTH'(cw - sw)};
    else if (SATURATE != 0)  res = {1'b1, {WIDTH{1'b0}}};
    else                     res = {1'b1, WIDTH'(cw - sw + MOD_EXT)};
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return ({1'b0, v} > MAX_EXT) ? MAX_W : v;
  endfunction

  logic [WIDTH-1:0] count_nxt;
  logic             carry_nxt;
  logic [WIDTH:0]   step_res;

  always_comb begin
    count_nxt = count;
    carry_nxt = 1'b0;
    step_res  = '0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = clamp_load(load_val);
    end else if (en) begin
      step_res  = up ? step_up(count, step) : step_dn(count, step);
      carry_nxt = step_res[WIDTH];
      count_nxt = WIDTH'(step_res);
    end
  end

  // Register stage: count, carry pulse and sticky overflow (set beats clear)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      carry      <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      count <= count_nxt;
      carry <= carry_nxt;
      if (carry_nxt)    ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  end

  assign at_max = ({1'b0, count} == MAX_EXT);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_step_counter.sv
// Directed bench for step_counter: default 8-bit wrap, decade wrap (0..9) and decade saturate instances.
module tb_step_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b1, ovf_clr = 1'b0;
  logic [7:0] lv = 8'd0;
  logic [3:0] st = 4'd0;

  logic [7:0] dcnt;
  logic       dcar, dmax, dmin, dstk;
  logic [3:0] ccnt;
  logic       ccar, cmax, cmin, cstk;
  logic [3:0] scnt;
  logic       scar, smax, smin, sstk;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  step_counter u_def (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv), .en(en), .up(up),
    .step(st), .ovf_clr(ovf_clr), .count(dcnt), .carry(dcar), .at_max(dmax), .at_min(dmin),
    .ovf_sticky(dstk)
  );

  step_counter #(.WIDTH(4), .STEP_W(3), .MAX_VAL(9), .SATURATE(0)) u_dec (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv[3:0]), .en(en), .up(up),
    .step(st[2:0]), .ovf_clr(ovf_clr), .count(ccnt), .carry(ccar), .at_max(cmax), .at_min(cmin),
    .ovf_sticky(cstk)
  );

  step_counter #(.WIDTH(4), .STEP_W(3), .MAX_VAL(9), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv[3:0]), .en(en), .up(up),
    .step(st[2:0]), .ovf_clr(ovf_clr), .count(scnt), .carry(scar), .at_max(smax), .at_min(smin),
    .ovf_sticky(sstk)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (dcnt !== 8'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", dcnt); end
    total++; if (dcar !== 1'b0) begin bad++; $display("FAIL rst_carry got=%b want=0", dcar); end
    total++; if (dstk !== 1'b0) begin bad++; $display("FAIL rst_sticky got=%b want=0", dstk); end
    total++; if (dmin !== 1'b1) begin bad++; $display("FAIL rst_at_min got=%b want=1", dmin); end
    total++; if (dmax !== 1'b0) begin bad++; $display("FAIL rst_at_max got=%b want=0", dmax); end
    @(negedge clk);
    reset = 1'b1;
    load = 1'b1; lv = 8'hFA;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1; st = 4'd15;
    tick();
    // 250 + 15 = 265 wraps to 9 in the 256-state counter
    total++; if (dcnt !== 8'd9) begin bad++; $display("FAIL wrap8_count got=%0d want=9", dcnt); end
    total++; if (dcar !== 1'b1) begin bad++; $display("FAIL wrap8_carry got=%b want=1", dcar); end
    total++; if (dstk !== 1'b1) begin bad++; $display("FAIL wrap8_sticky got=%b want=1", dstk); end
    en = 1'b0; load = 1'b1; lv = 8'h37;
    tick();
    load = 1'b0;
    total++; if (dcnt !== 8'h37) begin bad++; $display("FAIL load37_count got=%0h want=37", dcnt); end
    total++; if (dcar !== 1'b0) begin bad++; $display("FAIL load37_carry got=%b want=0", dcar); end
    total++; if (dstk !== 1'b1) begin bad++; $display("FAIL load37_sticky got=%b want=1", dstk); end
    #3;
    reset = 1'b0;
    #1;
    total++; if (dcnt !== 8'd0) begin bad++; $display("FAIL async_rst_count got=%0d want=0", dcnt); end
    total++; if (dcar !== 1'b0) begin bad++; $display("FAIL async_rst_carry got=%b want=0", dcar); end
    total++; if (dstk !== 1'b0) begin bad++; $display("FAIL async_rst_sticky got=%b want=0", dstk); end
    total++; if (dmin !== 1'b1) begin bad++; $display("FAIL async_rst_at_min got=%b want=1", dmin); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_decade_wrap();
    clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1; up = 1'b1; st = 4'd1;
    total++; if (ccnt !== 4'd0) begin bad++; $display("FAIL dec_start got=%0d want=0", ccnt); end
    total++; if (cstk !== 1'b0) begin bad++; $display("FAIL dec_start_sticky got=%b want=0", cstk); end
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++; if (ccnt !== 4'(i)) begin bad++; $display("FAIL dec_count[%0d] got=%0d want=%0d", i, ccnt, i); end
      total++; if (ccar !== 1'b0) begin bad++; $display("FAIL dec_carry[%0d] got=%b want=0", i, ccar); end
    end
    total++; if (cmax !== 1'b1) begin bad++; $display("FAIL dec_at_max got=%b want=1", cmax); end
    tick();
    total++; if (ccnt !== 4'd0) begin bad++; $display("FAIL dec_wrap_count got=%0d want=0", ccnt); end
    total++; if (ccar !== 1'b1) begin bad++; $display("FAIL dec_wrap_carry got=%b want=1", ccar); end
    total++; if (cmin !== 1'b1) begin bad++; $display("FAIL dec_wrap_at_min got=%b want=1", cmin); end
    tick();
    total++; if (ccnt !== 4'd1) begin bad++; $display("FAIL dec_after_count got=%0d want=1", ccnt); end
    total++; if (ccar !== 1'b0) begin bad++; $display("FAIL dec_after_carry got=%b want=0", ccar); end
    total++; if (cstk !== 1'b1) begin bad++; $display("FAIL dec_after_sticky got=%b want=1", cstk); end
    en = 1'b0;
  endtask

  task automatic test_step_wrap_down();
    load = 1'b1; lv = 8'd2;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0; st = 4'd5;
    tick();
    // 2 - 5 modulo 10 is 7; saturating variant clamps at 0
    total++; if (ccnt !== 4'd7) begin bad++; $display("FAIL wdn_count got=%0d want=7", ccnt); end
    total++; if (ccar !== 1'b1) begin bad++; $display("FAIL wdn_carry got=%b want=1", ccar); end
    total++; if (scnt !== 4'd0) begin bad++; $display("FAIL sdn_count got=%0d want=0", scnt); end
    total++; if (scar !== 1'b1) begin bad++; $display("FAIL sdn_carry got=%b want=1", scar); end
    tick();
    total++; if (scnt !== 4'd0) begin bad++; $display("FAIL sdn2_count got=%0d want=0", scnt); end
    total++; if (scar !== 1'b1) begin bad++; $display("FAIL sdn2_carry got=%b want=1", scar); end
    total++; if (ccnt !== 4'd2) begin bad++; $display("FAIL wdn2_count got=%0d want=2", ccnt); end
    total++; if (ccar !== 1'b0) begin bad++; $display("FAIL wdn2_carry got=%b want=0", ccar); end
    en = 1'b0; up = 1'b1;
  endtask

  task automatic test_priority();
    clr = 1'b1; load = 1'b1; en = 1'b1; lv = 8'd5; st = 4'd3; up = 1'b1;
    tick();
    total++; if (ccnt !== 4'd0) begin bad++; $display("FAIL prio_clr got=%0d want=0", ccnt); end
    clr = 1'b0;
    tick();
    total++; if (ccnt !== 4'd5) begin bad++; $display("FAIL prio_load got=%0d want=5", ccnt); end
    total++; if (ccar !== 1'b0) begin bad++; $display("FAIL prio_carry got=%b want=0", ccar); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_load_clamp();
    load = 1'b1; lv = 8'd14;
    tick();
    total++; if (ccnt !== 4'd9) begin bad++; $display("FAIL clamp_count got=%0d want=9", ccnt); end
    total++; if (ccar !== 1'b0) begin bad++; $display("FAIL clamp_carry got=%b want=0", ccar); end
    total++; if (dcnt !== 8'd14) begin bad++; $display("FAIL noclamp8_count got=%0d want=14", dcnt); end
    load = 1'b0; en = 1'b1; st = 4'd0;
    tick();
    total++; if (ccnt !== 4'd9) begin bad++; $display("FAIL step0_count got=%0d want=9", ccnt); end
    total++; if (ccar !== 1'b0) begin bad++; $display("FAIL step0_carry got=%b want=0", ccar); end
    en = 1'b0;
  endtask

  task automatic test_sticky_race();
    ovf_clr = 1'b1;
    tick();
    total++; if (cstk !== 1'b0) begin bad++; $display("FAIL stk_pre_clr got=%b want=0", cstk); end
    en = 1'b1; up = 1'b1; st = 4'd1;
    tick();
    total++; if (ccnt !== 4'd0) begin bad++; $display("FAIL race_count got=%0d want=0", ccnt); end
    total++; if (ccar !== 1'b1) begin bad++; $display("FAIL race_carry got=%b want=1", ccar); end
    total++; if (cstk !== 1'b1) begin bad++; $display("FAIL race_sticky got=%b want=1", cstk); end
    en = 1'b0;
    tick();
    total++; if (cstk !== 1'b0) begin bad++; $display("FAIL stk_clr got=%b want=0", cstk); end
    total++; if (ccar !== 1'b0) begin bad++; $display("FAIL stk_clr_carry got=%b want=0", ccar); end
    ovf_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    load = 1'b1; lv = 8'd8;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1; st = 4'd1;
    tick();
    total++; if (scnt !== 4'd9) begin bad++; $display("FAIL sup_count got=%0d want=9", scnt); end
    total++; if (scar !== 1'b0) begin bad++; $display("FAIL sup_carry got=%b want=0", scar); end
    total++; if (smax !== 1'b1) begin bad++; $display("FAIL sup_at_max got=%b want=1", smax); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (scnt !== 4'd9) begin bad++; $display("FAIL sclamp_count[%0d] got=%0d want=9", i, scnt); end
      total++; if (scar !== 1'b1) begin bad++; $display("FAIL sclamp_carry[%0d] got=%b want=1", i, scar); end
    end
    total++; if (sstk !== 1'b1) begin bad++; $display("FAIL sclamp_sticky got=%b want=1", sstk); end
    en = 1'b0;
    tick();
    total++; if (scar !== 1'b0) begin bad++; $display("FAIL sidle_carry got=%b want=0", scar); end
  endtask

  initial begin
    test_reset();
    test_decade_wrap();
    test_step_wrap_down();
    test_priority();
    test_load_clamp();
    test_sticky_race();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_counter.md
Name: step_counter

Overview:
- Parametrised successor to the single-bit +1 incrementer: a registered WIDTH-bit up/down counter with programmable step, modulus, wrap or saturate mode, synchronous load/clear and overflow reporting.
- Used as the general counting primitive: decade/BCD digits, address generators, timers.
- The increment/decrement datapath is built from the team's adder cells.
- All state is held in flops clocked by clk.

Parameters:
- WIDTH, 8, counter width in bits.
- STEP_W, 4, width of the step input.
- MAX_VAL, 2**WIDTH-1, terminal value; counter range is 0..MAX_VAL (modulus MAX_VAL+1).
- SATURATE, 0, 0 = wrap-around mode, 1 = clamp at 0 / MAX_VAL.
- Elaboration check: MAX_VAL < 2**WIDTH and 2**STEP_W-1 <= MAX_VAL; violation is a fatal elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable.
- up  in  1  direction: 1 = count += step, 0 = count -= step.
- step  in  STEP_W  step size, unsigned.
- ovf_clr  in  1  clears ovf_sticky.
- count  out  WIDTH  registered counter value.
- carry  out  1  one-cycle pulse: wrap or clamp occurred on this update.
- at_max  out  1  count == MAX_VAL.
- at_min  out  1  count == 0.
- ovf_sticky  out  1  set by any carry event, held until ovf_clr.

Behaviour:
- Reset (reset = 0, asynchronous assert, synchronous-to-clk release): count = 0, carry = 0, ovf_sticky = 0. at_min = 1, at_max = (MAX_VAL == 0).
- Reset asserted mid-count forces the reset values immediately, without waiting for a clock edge.
- Priority per rising edge: clr > load > en. Lower-priority requests in the same cycle are ignored.
- clr: count <= 0; carry <= 0.
- load: count <= min(load_val, MAX_VAL); carry <= 0.
- en with up = 1, sum = count + step computed at WIDTH+1 bits:
  - sum <= MAX_VAL: count <= sum; carry <= 0.
  - sum > MAX_VAL, wrap mode: count <= sum - (MAX_VAL+1); carry <= 1.
  - sum > MAX_VAL, saturate mode: count <= MAX_VAL; carry <= 1.
- en with up = 0:
  - step <= count: count <= count - step; carry <= 0.
  - step > count, wrap mode: count <= count - step + MAX_VAL + 1; carry <= 1.
  - step > count, saturate mode: count <= 0; carry <= 1.
- step = 0 with en = 1: count holds; carry <= 0.
- In saturate mode, sitting at a limit and stepping further still pulses carry each cycle.
- en = 0 and no clr/load: count holds; carry <= 0.
- Latency: one clock from request to count/carry update.
- carry is registered and lasts exactly one cycle per event.
- at_max and at_min are decoded combinationally from the count register only.
- ovf_sticky:
  - set when the next carry = 1.
  - cleared by ovf_clr.
  - simultaneous set and ovf_clr: set wins (stays 1).
- Step constraint guarantees at most one wrap per update; no multi-wrap handling is required.

Test Plan:
- Reset: WIDTH=8 defaults; assert reset mid-count at count=0x37 between clock edges -> count=0, carry=0, ovf_sticky=0 immediately; at_min=1.
- Decade wrap: WIDTH=4, MAX_VAL=9, SATURATE=0, step=1, up=1 from 0 -> 0..9 then 0 on the 10th edge; carry=1 for exactly that cycle; at_max=1 at 9; ovf_sticky=1 afterwards.
- Step wrap down: MAX_VAL=9, count=2, step=5, up=0 -> count=7, carry=1. Same case with SATURATE=1 -> count=0, carry=1. A further edge with step=5 -> count=0, carry=1 again.
- Priority: clr=1, load=1, en=1, load_val=5 -> count=0. Next cycle load=1, en=1, load_val=5, step=3 -> count=5, not 8.
- Load clamp and step=0: MAX_VAL=9, load_val=14 -> count=9, carry=0. Then en=1, step=0 -> count stays 9, carry=0.
- Sticky clear race: carry event and ovf_clr=1 on the same edge -> ovf_sticky=1. ovf_clr=1 alone on the next edge -> ovf_sticky=0.
